// File: rtl/aes_host_queue_if.sv
// Host register port and core block port of aes_host_queue, bundled for module ports.
// slave = queue side, master = host/core side.
interface aes_host_queue_if #(
  parameter int DW = 8
);
  logic [DW-1:0]  DIN;
  logic [6:0]     ADDR;
  logic           WR;
  logic [DW-1:0]  DOUT;
  logic           OK;
  logic           t_valid;
  logic           t_ready;
  logic [127:0]   Plain_text;
  logic           op;
  logic [3:0]     Nr;
  logic [3:0]     Nk_val;
  logic [255:0]   CipherKey;
  logic           c_valid;
  logic [127:0]   Ciphertext;

  modport slave (
    input  DIN, ADDR, WR, t_ready, c_valid, Ciphertext,
    output DOUT, OK, t_valid, Plain_text, op, Nr, Nk_val, CipherKey
  );

  modport master (
    output DIN, ADDR, WR, t_ready, c_valid, Ciphertext,
    input  DOUT, OK, t_valid, Plain_text, op, Nr, Nk_val, CipherKey
  );
endinterface

// File: rtl/aes_host_queue.sv
// Host-side register front end for the AES core: staging/key/CFG registers plus
// DEPTH-entry input and output block FIFOs with credit-based core handshake.
module aes_host_queue #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input logic              CLK,
  input logic              RSTB,
  aes_host_queue_if.slave  hq
);
  localparam int unsigned BPW = DW / 8;
  localparam int unsigned TW  = 16 / BPW;
  localparam int unsigned KW  = 32 / BPW;
  localparam int          AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW  = $clog2(DEPTH + 1);

  logic [127:0]   stage;
  logic [255:0]   key;
  logic           cfg_op;
  logic [2:0]     cfg_nk;
  logic           err;

  logic [128:0]   in_mem  [DEPTH];
  logic [127:0]   out_mem [DEPTH];
  logic [AW-1:0]  in_rd, in_wr, out_rd, out_wr;
  logic [CW-1:0]  in_cnt, out_cnt, inflight;
  logic [CW-1:0]  in_cnt_n, out_cnt_n, inflight_n;
  logic [CW:0]    credit_sum;

  logic sel_text, sel_out, sel_key, sel_cfg, sel_cmd, sel_stat;
  logic text_ok, key_ok, locked, nk_ok;
  logic in_empty, in_full, out_empty, out_full, busy;
  logic push_req, pop_req, clr_req, push_ok, pop_ok, xfer, res_ok, err_set;
  logic [DW-1:0] rdata;

  always_comb begin
    sel_text = (hq.ADDR[6:4] == 3'd0);
    sel_out  = (hq.ADDR[6:4] == 3'd1);
    sel_key  = (hq.ADDR[6:5] == 2'b01);
    sel_cfg  = (hq.ADDR == 7'h40);
    sel_cmd  = (hq.ADDR == 7'h41);
    sel_stat = (hq.ADDR == 7'h42);
    text_ok  = 32'(hq.ADDR[3:0]) < TW;
    key_ok   = 32'(hq.ADDR[4:0]) < KW;

    in_empty  = (in_cnt == '0);
    in_full   = (in_cnt == CW'(DEPTH));
    out_empty = (out_cnt == '0);
    out_full  = (out_cnt == CW'(DEPTH));
    busy      = (inflight != '0);
    locked    = !in_empty || busy;
    nk_ok     = (cfg_nk == 3'd3) || (cfg_nk == 3'd5) || (cfg_nk == 3'd7);

    push_req = hq.WR && sel_cmd && hq.DIN[0];
    pop_req  = hq.WR && sel_cmd && hq.DIN[1];
    clr_req  = hq.WR && sel_cmd && hq.DIN[2];
    push_ok  = push_req && !in_full && nk_ok;
    pop_ok   = pop_req && !out_empty;
    xfer     = hq.t_valid && hq.t_ready;
    res_ok   = hq.c_valid && busy && !out_full;

    err_set = (hq.WR && (sel_key || sel_cfg) && locked)
            || (push_req && !push_ok)
            || (pop_req && out_empty)
            || (hq.c_valid && !busy);

    in_cnt_n   = in_cnt + CW'(push_ok) - CW'(xfer);
    out_cnt_n  = out_cnt + CW'(res_ok) - CW'(pop_ok);
    inflight_n = inflight + CW'(xfer) - CW'(res_ok);
  end

  // Credit counts results already owed to the output FIFO, so a block is only
  // released to the core when its result is guaranteed a slot.
  assign credit_sum    = {1'b0, out_cnt} + {1'b0, inflight};
  assign hq.t_valid    = !in_empty && (credit_sum < (CW + 1)'(DEPTH));
  assign hq.Plain_text = in_mem[in_rd][127:0];
  assign hq.op         = in_mem[in_rd][128];

  always_comb begin
    hq.Nr        = '0;
    hq.Nk_val    = '0;
    hq.CipherKey = '0;
    case (cfg_nk)
      3'd3: begin
        hq.Nr = 4'd10; hq.Nk_val = 4'd4; hq.CipherKey = {128'b0, key[127:0]};
      end
      3'd5: begin
        hq.Nr = 4'd12; hq.Nk_val = 4'd6; hq.CipherKey = {64'b0, key[191:0]};
      end
      3'd7: begin
        hq.Nr = 4'd14; hq.Nk_val = 4'd8; hq.CipherKey = key;
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (sel_text && text_ok)
      rdata = stage[7'(DW * hq.ADDR[3:0]) +: DW];
    else if (sel_out && text_ok && !out_empty)
      rdata = out_mem[out_rd][7'(DW * hq.ADDR[3:0]) +: DW];
    else if (sel_key && key_ok)
      rdata = key[8'(DW * hq.ADDR[4:0]) +: DW];
    else if (sel_cfg)
      rdata = DW'({4'b0, cfg_nk, cfg_op});
    else if (sel_stat)
      rdata = DW'({2'b0, busy, err, out_full, out_empty, in_full, in_empty});
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      stage    <= '0;
      key      <= '0;
      cfg_op   <= 1'b0;
      cfg_nk   <= '0;
      err      <= 1'b0;
      in_rd    <= '0;
      in_wr    <= '0;
      out_rd   <= '0;
      out_wr   <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      inflight <= '0;
      hq.DOUT  <= '0;
      hq.OK    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        in_mem[i]  <= '0;
        out_mem[i] <= '0;
      end
    end else begin
      if (hq.WR && sel_text && text_ok)
        stage[7'(DW * hq.ADDR[3:0]) +: DW] <= hq.DIN;
      if (hq.WR && sel_key && key_ok && !locked)
        key[8'(DW * hq.ADDR[4:0]) +: DW] <= hq.DIN;
      if (hq.WR && sel_cfg && !locked) begin
        cfg_op <= hq.DIN[0];
        cfg_nk <= hq.DIN[3:1];
      end

      if (push_ok) begin
        in_mem[in_wr] <= {cfg_op, stage};
        in_wr         <= in_wr + AW'(1);
      end
      if (xfer)
        in_rd <= in_rd + AW'(1);
      if (res_ok) begin
        out_mem[out_wr] <= hq.Ciphertext;
        out_wr          <= out_wr + AW'(1);
      end
      if (pop_ok)
        out_rd <= out_rd + AW'(1);

      in_cnt   <= in_cnt_n;
      out_cnt  <= out_cnt_n;
      inflight <= inflight_n;

      if (clr_req)
        err <= 1'b0;
      else if (err_set)
        err <= 1'b1;

      hq.DOUT <= hq.WR ? '0 : rdata;
      // OK follows the post-edge count so it tracks FIFO occupancy exactly.
      hq.OK   <= (out_cnt_n != '0);
    end
  end
endmodule

// File: tb/tb_aes_host_queue.sv
// Directed test of aes_host_queue: DW=8 instance for the queue/handshake behaviour,
// DW=32 instance for wide host word packing.
module tb_aes_host_queue;
  logic CLK;
  logic RSTB;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  aes_host_queue_if #(.DW(8))  h8 ();
  aes_host_queue_if #(.DW(32)) h32 ();

  aes_host_queue #(.DW(8), .DEPTH(4)) u8 (
    .CLK (CLK),
    .RSTB(RSTB),
    .hq  (h8.slave)
  );

  aes_host_queue #(.DW(32), .DEPTH(4)) u32 (
    .CLK (CLK),
    .RSTB(RSTB),
    .hq  (h32.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr8(input logic [6:0] a, input logic [7:0] d);
    @(negedge CLK);
    h8.WR = 1'b1; h8.ADDR = a; h8.DIN = d;
    @(negedge CLK);
    h8.WR = 1'b0; h8.ADDR = '0; h8.DIN = '0;
  endtask

  task automatic rd8(input logic [6:0] a, output logic [7:0] d);
    @(negedge CLK);
    h8.WR = 1'b0; h8.ADDR = a;
    @(negedge CLK);
    d = h8.DOUT;
    h8.ADDR = '0;
  endtask

  task automatic wr32(input logic [6:0] a, input logic [31:0] d);
    @(negedge CLK);
    h32.WR = 1'b1; h32.ADDR = a; h32.DIN = d;
    @(negedge CLK);
    h32.WR = 1'b0; h32.ADDR = '0; h32.DIN = '0;
  endtask

  task automatic rd32(input logic [6:0] a, output logic [31:0] d);
    @(negedge CLK);
    h32.WR = 1'b0; h32.ADDR = a;
    @(negedge CLK);
    d = h32.DOUT;
    h32.ADDR = '0;
  endtask

  task automatic status8(input string tag, input logic [7:0] exp);
    logic [7:0] v;
    rd8(7'h42, v);
    check(tag, v, exp);
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_dout"},  h8.DOUT, '0);
    check({tag, "_ok"},    h8.OK, '0);
    check({tag, "_tval"},  h8.t_valid, '0);
    check({tag, "_pt"},    h8.Plain_text, '0);
    check({tag, "_op"},    h8.op, '0);
    check({tag, "_nr"},    h8.Nr, '0);
    check({tag, "_nk"},    h8.Nk_val, '0);
    check({tag, "_key"},   h8.CipherKey, '0);
  endtask

  initial begin
    logic [7:0]  r8;
    logic [31:0] r32;

    RSTB = 1'b0;
    h8.WR = 1'b0;  h8.ADDR = '0;  h8.DIN = '0;
    h8.t_ready = 1'b0; h8.c_valid = 1'b0; h8.Ciphertext = '0;
    h32.WR = 1'b0; h32.ADDR = '0; h32.DIN = '0;
    h32.t_ready = 1'b0; h32.c_valid = 1'b0; h32.Ciphertext = '0;

    repeat (3) @(negedge CLK);
    outputs_zero("reset");
    RSTB = 1'b1;

    // Basic path: FIPS-197 AES-128 vector
    for (int i = 0; i < 16; i++) wr8(7'(8'h20 + i), 8'(i));
    wr8(7'h40, 8'h07);
    for (int i = 0; i < 16; i++) wr8(7'(i), 8'(i * 17));
    rd8(7'h0F, r8);
    check("stage_rd", r8, 8'hFF);
    h8.WR = 1'b1; h8.ADDR = 7'h05; h8.DIN = 8'h55;
    @(negedge CLK);
    h8.WR = 1'b0; h8.ADDR = '0; h8.DIN = '0;
    check("dout_on_write", h8.DOUT, 8'h00);
    rd8(7'h40, r8);
    check("cfg_rd", r8, 8'h07);
    status8("status_idle", 8'h05);

    wr8(7'h41, 8'h01);
    check("push_tvalid", h8.t_valid, 1'b1);
    check("push_pt", h8.Plain_text, 128'hFFEEDDCCBBAA99887766554433221100);
    check("push_op", h8.op, 1'b1);
    check("nr10", h8.Nr, 4'd10);
    check("nk4", h8.Nk_val, 4'd4);
    check("cipherkey", h8.CipherKey, 256'h0F0E0D0C0B0A09080706050403020100);

    @(negedge CLK); h8.t_ready = 1'b1;
    @(negedge CLK); h8.t_ready = 1'b0;
    check("xfer_tvalid", h8.t_valid, 1'b0);
    status8("status_busy", 8'h25);

    // Key write while busy is locked out
    wr8(7'h20, 8'hAA);
    rd8(7'h20, r8);
    check("key_locked", r8, 8'h00);
    check("key_locked_out", h8.CipherKey, 256'h0F0E0D0C0B0A09080706050403020100);
    status8("status_lock_err", 8'h35);

    @(negedge CLK);
    h8.c_valid = 1'b1; h8.Ciphertext = 128'h5AC5B47080B7CDD830047B6AD8E0C469;
    @(negedge CLK);
    h8.c_valid = 1'b0;
    check("ok_rise", h8.OK, 1'b1);
    rd8(7'h10, r8);
    check("ct_byte0", r8, 8'h69);
    rd8(7'h1F, r8);
    check("ct_byte15", r8, 8'h5A);

    wr8(7'h41, 8'h04);
    status8("status_clr", 8'h01);
    wr8(7'h41, 8'h02);
    check("ok_fall", h8.OK, 1'b0);
    status8("status_popped", 8'h05);
    wr8(7'h41, 8'h02);
    status8("pop_empty_err", 8'h15);
    wr8(7'h41, 8'h04);

    // Invalid NK rejects PUSH
    wr8(7'h40, 8'h09);
    check("nk_bad_nr", h8.Nr, 4'd0);
    wr8(7'h41, 8'h01);
    status8("nk_bad_push", 8'h15);
    wr8(7'h41, 8'h04);
    status8("nk_bad_clr", 8'h05);
    wr8(7'h40, 8'h07);

    // Queue full: five pushes, four accepted
    for (int j = 0; j < 5; j++) begin
      wr8(7'h00, 8'(8'h10 + j));
      wr8(7'h41, 8'h01);
    end
    status8("queue_full", 8'h16);
    @(negedge CLK);
    h8.t_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("drain_valid%0d", j), h8.t_valid, 1'b1);
      check($sformatf("drain_order%0d", j), h8.Plain_text[7:0], 8'(8'h10 + j));
      @(negedge CLK);
    end
    h8.t_ready = 1'b0;
    check("credit_stop", h8.t_valid, 1'b0);
    status8("drained", 8'h35);
    wr8(7'h41, 8'h04);

    // Credit: four results owed, one queued input waits
    wr8(7'h00, 8'h77);
    wr8(7'h41, 8'h01);
    check("credit_block", h8.t_valid, 1'b0);
    for (int j = 0; j < 4; j++) begin
      @(negedge CLK);
      h8.c_valid = 1'b1;
      h8.Ciphertext = {120'h0, 8'(8'hA0 + j)};
    end
    @(negedge CLK);
    h8.c_valid = 1'b0;
    check("credit_full_out", h8.t_valid, 1'b0);
    status8("out_full", 8'h08);
    rd8(7'h10, r8);
    check("out_order0", r8, 8'hA0);
    wr8(7'h41, 8'h02);
    check("credit_release", h8.t_valid, 1'b1);
    check("credit_head", h8.Plain_text[7:0], 8'h77);
    rd8(7'h10, r8);
    check("out_order1", r8, 8'hA1);

    // Reset mid-operation: one inflight, two queued
    @(negedge CLK); h8.t_ready = 1'b1;
    @(negedge CLK); h8.t_ready = 1'b0;
    wr8(7'h41, 8'h01);
    wr8(7'h41, 8'h01);
    status8("pre_reset", 8'h20);
    @(negedge CLK);
    RSTB = 1'b0;
    #1;
    outputs_zero("midreset");
    @(negedge CLK);
    RSTB = 1'b1;
    status8("post_reset", 8'h05);

    // DW=32 word packing
    wr32(7'h40, 32'h7);
    wr32(7'h03, 32'hFFEEDDCC);
    rd32(7'h03, r32);
    check("w32_rd3", r32, 32'hFFEEDDCC);
    rd32(7'h04, r32);
    check("w32_rd4", r32, 32'h0);
    wr32(7'h41, 32'h1);
    check("w32_pt", h32.Plain_text, 128'hFFEEDDCC_00000000_00000000_00000000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
